// File: rtl/rms_tracker_pkg.sv
// Shared types and helpers for the time-multiplexed mean/deviation tracker.
package rms_tracker_pkg;

    typedef enum logic [1:0] {IDLE, DELTA, UPDATE, DONE} state_t;

    function automatic int acc_width(input int dw, input int k);
        return dw + k;
    endfunction

    function automatic int ch_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    // Clamp a signed value into the unsigned range [0, 2^w - 1].
    function automatic logic [63:0] clamp_u(input logic signed [63:0] v, input int w);
        logic signed [63:0] mx;
        mx = (64'sd1 <<< w) - 64'sd1;
        if (v < 64'sd0) return '0;
        if (v > mx) return mx;
        return v;
    endfunction

endpackage

// File: rtl/rms_tracker_n_ema.sv
// One exponential-average step: acc + target - (acc >> SH), clamped to AW bits.
module ema_step
    import rms_tracker_pkg::*;
#(
    parameter int AW = 31,
    parameter int DW = 16,
    parameter int SH = 15
) (
    input  logic [AW-1:0] acc,
    input  logic [DW-1:0] target,
    output logic [AW-1:0] acc_next
);

    logic signed [63:0] sum;

    always_comb begin
        sum      = 64'(acc) + 64'(target) - 64'(acc >> SH);
        acc_next = AW'(clamp_u(sum, AW));
    end

endmodule

// File: rtl/rms_tracker_n.sv
// Snapshots N_CH samples per trigger edge and sweeps them through one shared
// mean/deviation datapath, publishing a coherent MEAN/RMS bank at the end.
module rms_tracker_n
    import rms_tracker_pkg::*;
#(
    parameter int N_CH      = 8,
    parameter int DW        = 16,
    parameter int KM        = 15,
    parameter int KR        = 13,
    parameter int MODE      = 0,
    parameter int SQ_SHIFT  = 16,
    parameter int READY_LEN = 5
) (
    input  logic               M_CLK,
    input  logic               RST,
    input  logic               TRIGGER,
    input  logic [N_CH*DW-1:0] NEW_DATA,
    output logic [N_CH*DW-1:0] MEAN,
    output logic [N_CH*DW-1:0] RMS,
    output logic               DATA_READY,
    output logic               BUSY,
    output logic               OVERRUN,
    output state_t             dbg_state
);

    localparam int MACC_W = acc_width(DW, KM);
    localparam int RACC_W = acc_width(DW, KR);
    localparam int CH_W   = ch_width(N_CH);
    localparam int RC_W   = $clog2(READY_LEN + 1);
    localparam logic [MACC_W-1:0] MACC_INIT = MACC_W'(1) << (DW - 1 + KM);
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(N_CH - 1);

    state_t            state_q, state_d;
    logic [1:0]        sync_q;
    logic              trig_edge;
    logic [CH_W-1:0]   ch_q;
    logic [DW-1:0]     snap_q [N_CH];
    logic [MACC_W-1:0] macc_q [N_CH];
    logic [RACC_W-1:0] racc_q [N_CH];
    logic [DW-1:0]     s_q;
    logic [RC_W-1:0]   rdy_cnt_q;
    logic [DW-1:0]     x, m, d, s;
    logic [2*DW-1:0]   sq, sq_sh;
    logic [MACC_W-1:0] macc_next;
    logic [RACC_W-1:0] racc_next;

    assign trig_edge  = sync_q[0] & ~sync_q[1];
    assign BUSY       = (state_q != IDLE);
    assign DATA_READY = (rdy_cnt_q != '0);
    assign dbg_state  = state_q;

    // Deviation term for the current channel, taken against the pre-update mean.
    always_comb begin
        x     = snap_q[ch_q];
        m     = DW'(macc_q[ch_q] >> KM);
        d     = (x >= m) ? (x - m) : (m - x);
        sq    = (2*DW)'(d) * (2*DW)'(d);
        sq_sh = sq >> SQ_SHIFT;
        s     = d;
        if (MODE != 0) s = (|sq_sh[2*DW-1:DW]) ? '1 : sq_sh[DW-1:0];
    end

    ema_step #(.AW(MACC_W), .DW(DW), .SH(KM)) u_mean_step (
        .acc      (macc_q[ch_q]),
        .target   (x),
        .acc_next (macc_next)
    );

    ema_step #(.AW(RACC_W), .DW(DW), .SH(KR)) u_rms_step (
        .acc      (racc_q[ch_q]),
        .target   (s_q),
        .acc_next (racc_next)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (trig_edge) state_d = DELTA;
            DELTA:   state_d = UPDATE;
            UPDATE:  state_d = (ch_q == LAST_CH) ? DONE : DELTA;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge M_CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge M_CLK or posedge RST) begin
        if (RST) begin
            sync_q    <= '0;
            ch_q      <= '0;
            s_q       <= '0;
            rdy_cnt_q <= '0;
            OVERRUN   <= 1'b0;
            MEAN      <= '0;
            RMS       <= '0;
            for (int c = 0; c < N_CH; c++) begin
                snap_q[c] <= '0;
                macc_q[c] <= MACC_INIT;
                racc_q[c] <= '0;
            end
        end else begin
            sync_q  <= {sync_q[0], TRIGGER};
            OVERRUN <= trig_edge && (state_q != IDLE);
            if (rdy_cnt_q != '0) rdy_cnt_q <= rdy_cnt_q - RC_W'(1);
            case (state_q)
                IDLE: begin
                    if (trig_edge) begin
                        for (int c = 0; c < N_CH; c++) snap_q[c] <= NEW_DATA[c*DW +: DW];
                        ch_q      <= '0;
                        rdy_cnt_q <= '0;
                    end
                end
                DELTA: s_q <= s;
                UPDATE: begin
                    macc_q[ch_q] <= macc_next;
                    racc_q[ch_q] <= racc_next;
                    ch_q         <= (ch_q == LAST_CH) ? '0 : ch_q + CH_W'(1);
                end
                DONE: begin
                    // Whole bank in one edge so readers never see a mixed sweep.
                    for (int c = 0; c < N_CH; c++) begin
                        MEAN[c*DW +: DW] <= DW'(macc_q[c] >> KM);
                        RMS[c*DW +: DW]  <= DW'(racc_q[c] >> KR);
                    end
                    rdy_cnt_q <= RC_W'(READY_LEN);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rms_tracker_n.sv
// Bench for rms_tracker_n: two instances (MODE 0 and MODE 1) driven in parallel.
module tb_rms_tracker_n;

    localparam int N_CH = 4;
    localparam int DW   = 16;
    localparam int KM   = 4;
    localparam int KR   = 2;
    localparam int SQ1  = 8;
    localparam int RLEN = 5;
    localparam int NW   = N_CH * DW;

    logic          M_CLK;
    logic          RST;
    logic          TRIGGER;
    logic [NW-1:0] NEW_DATA;
    logic [NW-1:0] mean0, rms0, mean1, rms1;
    logic [1:0]    dr, busy, ov;
    rms_tracker_pkg::state_t st0, st1;

    int checks   = 0;
    int failures = 0;

    longint macc_m [N_CH];
    longint racc_m [2][N_CH];
    longint exp_mean [N_CH];
    longint exp_rms [2][N_CH];

    typedef struct {
        logic [15:0] ch0;
        logic [15:0] mean0;
        logic [15:0] rms0_m0;
        logic [15:0] rms0_m1;
    } vec_t;
    vec_t vecs [4];

    rms_tracker_n #(.N_CH(N_CH), .DW(DW), .KM(KM), .KR(KR), .MODE(0), .SQ_SHIFT(16),
                    .READY_LEN(RLEN)) u_dut0 (
        .M_CLK(M_CLK), .RST(RST), .TRIGGER(TRIGGER), .NEW_DATA(NEW_DATA),
        .MEAN(mean0), .RMS(rms0), .DATA_READY(dr[0]), .BUSY(busy[0]),
        .OVERRUN(ov[0]), .dbg_state(st0)
    );

    rms_tracker_n #(.N_CH(N_CH), .DW(DW), .KM(KM), .KR(KR), .MODE(1), .SQ_SHIFT(SQ1),
                    .READY_LEN(RLEN)) u_dut1 (
        .M_CLK(M_CLK), .RST(RST), .TRIGGER(TRIGGER), .NEW_DATA(NEW_DATA),
        .MEAN(mean1), .RMS(rms1), .DATA_READY(dr[1]), .BUSY(busy[1]),
        .OVERRUN(ov[1]), .dbg_state(st1)
    );

    // Clock / reset
    initial begin
        M_CLK = 1'b0;
        forever #5 M_CLK = ~M_CLK;
    end

    task automatic tick();
        @(posedge M_CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: per-channel exponential averages in plain integers.
    function automatic longint clampv(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        if (v < 0) return 0;
        if (v > mx) return mx;
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            macc_m[c]    = longint'(16'h8000) << KM;
            racc_m[0][c] = 0;
            racc_m[1][c] = 0;
            exp_mean[c]  = 0;
            exp_rms[0][c] = 0;
            exp_rms[1][c] = 0;
        end
    endtask

    task automatic model_sweep(input logic [NW-1:0] data);
        longint x, m, dd, s0, s1;
        for (int c = 0; c < N_CH; c++) begin
            x  = longint'(data[c*DW +: DW]);
            m  = macc_m[c] / (longint'(1) << KM);
            dd = (x >= m) ? x - m : m - x;
            s0 = dd;
            s1 = (dd * dd) / (longint'(1) << SQ1);
            if (s1 > 65535) s1 = 65535;
            macc_m[c]    = clampv(macc_m[c] + x - m, DW + KM);
            racc_m[0][c] = clampv(racc_m[0][c] + s0 - racc_m[0][c] / (longint'(1) << KR), DW + KR);
            racc_m[1][c] = clampv(racc_m[1][c] + s1 - racc_m[1][c] / (longint'(1) << KR), DW + KR);
            exp_mean[c]   = macc_m[c] / (longint'(1) << KM);
            exp_rms[0][c] = racc_m[0][c] / (longint'(1) << KR);
            exp_rms[1][c] = racc_m[1][c] / (longint'(1) << KR);
        end
    endtask

    function automatic logic [15:0] get_mean(input int k, input int c);
        return (k == 0) ? mean0[c*DW +: DW] : mean1[c*DW +: DW];
    endfunction

    function automatic logic [15:0] get_rms(input int k, input int c);
        return (k == 0) ? rms0[c*DW +: DW] : rms1[c*DW +: DW];
    endfunction

    task automatic check_bank(input string tag);
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < N_CH; c++) begin
                chk($sformatf("%s mean m%0d ch%0d", tag, k, c), 64'(get_mean(k, c)), exp_mean[c]);
                chk($sformatf("%s rms m%0d ch%0d", tag, k, c), 64'(get_rms(k, c)), exp_rms[k][c]);
            end
    endtask

    // Driver tasks
    task automatic do_reset();
        RST = 1'b1;
        TRIGGER = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        tick();
        model_reset();
    endtask

    task automatic sweep(input logic [NW-1:0] data, input int second_at, input int exp_ov,
                         input string tag);
        int rises [2];
        int rise_t [2];
        int dr_len [2];
        int ov_cnt [2];
        logic dr_prev [2];
        int after;
        for (int k = 0; k < 2; k++) begin
            rises[k] = 0; rise_t[k] = -1; dr_len[k] = 0; ov_cnt[k] = 0; dr_prev[k] = dr[k];
        end
        NEW_DATA = data;
        model_sweep(data);
        after = -1;
        for (int t = 0; t < 200; t++) begin
            TRIGGER = (t < 2) || (second_at > 0 && t >= second_at && t < second_at + 2);
            if (t == 2) NEW_DATA = NW'({$urandom(), $urandom()});
            tick();
            for (int k = 0; k < 2; k++) begin
                if (dr[k] && !dr_prev[k]) begin
                    rises[k]++;
                    rise_t[k] = t + 1;
                end
                if (dr[k]) dr_len[k]++;
                if (ov[k]) ov_cnt[k]++;
                dr_prev[k] = dr[k];
            end
            if (rises[0] > 0 && !dr[0] && after < 0) after = 0;
            if (after >= 0) begin
                after++;
                if (after > 20) break;
            end
        end
        TRIGGER = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s ready windows m%0d", tag, k), 64'(rises[k]), 64'd1);
            chk($sformatf("%s ready latency m%0d", tag, k), 64'(rise_t[k]), 64'(2*N_CH + 3));
            chk($sformatf("%s ready length m%0d", tag, k), 64'(dr_len[k]), 64'(RLEN));
            chk($sformatf("%s overrun pulses m%0d", tag, k), 64'(ov_cnt[k]), 64'(exp_ov));
        end
        check_bank(tag);
    endtask

    function automatic logic [NW-1:0] fill(input logic [15:0] v);
        logic [NW-1:0] r;
        for (int c = 0; c < N_CH; c++) r[c*DW +: DW] = v;
        return r;
    endfunction

    // Stimulus and scoreboard
    initial begin
        logic [NW-1:0] data;
        int n, dr_hits;

        vecs[0] = '{16'h8000, 16'h8000, 16'h0000, 16'h0000};
        vecs[1] = '{16'h8100, 16'h8010, 16'h0040, 16'h0040};
        vecs[2] = '{16'hFFFF, 16'h87FF, 16'h1FFF, 16'h3FFF};
        vecs[3] = '{16'h0000, 16'h7800, 16'h2000, 16'h3FFF};

        RST = 1'b1;
        TRIGGER = 1'b0;
        NEW_DATA = '0;
        do_reset();

        chk("reset data_ready", 64'(dr), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset overrun", 64'(ov), 64'd0);
        chk("reset state", 64'(st0), 64'(rms_tracker_pkg::IDLE));
        check_bank("reset");

        // Table-driven single sweeps from reset
        for (int i = 0; i < 4; i++) begin
            do_reset();
            data = fill(16'h8000);
            data[15:0] = vecs[i].ch0;
            sweep(data, 0, 0, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d mean0", i), 64'(mean0[15:0]), 64'(vecs[i].mean0));
            chk($sformatf("vec%0d mean1", i), 64'(mean1[15:0]), 64'(vecs[i].mean0));
            chk($sformatf("vec%0d rms mode0", i), 64'(rms0[15:0]), 64'(vecs[i].rms0_m0));
            chk($sformatf("vec%0d rms mode1", i), 64'(rms1[15:0]), 64'(vecs[i].rms0_m1));
        end

        // Second trigger 3 cycles in: one overrun, one window, single-trigger result
        do_reset();
        data = fill(16'h8000);
        data[15:0] = 16'h8100;
        sweep(data, 3, 1, "overrun");
        chk("overrun mean0", 64'(mean0[15:0]), 64'h8010);
        chk("overrun rms0", 64'(rms0[15:0]), 64'h0040);

        // Accepted edge inside the DATA_READY window drops it the next cycle
        data = fill(16'h7000);
        NEW_DATA = data;
        model_sweep(data);
        TRIGGER = 1'b1;
        tick();
        tick();
        TRIGGER = 1'b0;
        n = 0;
        while (!dr[0] && n < 60) begin
            tick();
            n++;
        end
        chk("window first ready", 64'(dr), 64'd3);
        model_sweep(data);
        TRIGGER = 1'b1;
        tick();
        tick();
        TRIGGER = 1'b0;
        chk("window ready dropped", 64'(dr), 64'd0);
        chk("window busy", 64'(busy), 64'd3);
        n = 0;
        while (!dr[0] && n < 60) begin
            tick();
            n++;
        end
        chk("window second ready", 64'(dr), 64'd3);
        check_bank("window");
        repeat (20) tick();

        // Reset in the middle of a sweep
        data = fill(16'h9000);
        NEW_DATA = data;
        TRIGGER = 1'b1;
        tick();
        tick();
        TRIGGER = 1'b0;
        repeat (4) tick();
        chk("midrst busy before", 64'(busy), 64'd3);
        RST = 1'b1;
        #1;
        chk("midrst mean0 zero", 64'(mean0), 64'd0);
        chk("midrst mean1 zero", 64'(mean1), 64'd0);
        chk("midrst rms0 zero", 64'(rms0), 64'd0);
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst ready", 64'(dr), 64'd0);
        tick();
        RST = 1'b0;
        model_reset();
        dr_hits = 0;
        for (int t = 0; t < 30; t++) begin
            tick();
            if (dr != 2'b00) dr_hits++;
        end
        chk("midrst no ready", 64'(dr_hits), 64'd0);
        check_bank("midrst");
        sweep(fill(16'h8000), 0, 0, "postrst");
        chk("postrst mean", 64'(mean0), 64'(fill(16'h8000)));

        // Randomized sweeps with persistent accumulators
        for (int i = 0; i < 20; i++) begin
            for (int c = 0; c < N_CH; c++) data[c*DW +: DW] = 16'($urandom_range(0, 65535));
            sweep(data, 0, 0, $sformatf("rand%0d", i));
        end

        // Long saturation runs at full scale then zero
        for (int i = 0; i < 200; i++) sweep(fill(16'hFFFF), 0, 0, $sformatf("hi%0d", i));
        chk("hi converged", 64'(mean0[15:0] >= 16'hFFF0), 64'd1);
        for (int i = 0; i < 200; i++) sweep(fill(16'h0000), 0, 0, $sformatf("lo%0d", i));
        chk("lo converged", 64'(mean0[15:0] <= 16'h0010), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
